axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Arbitrates the single AXI read channel between the instruction-fetch requester (ARID 0) and the data-load requester (ARID 1). It issues one AR beat at a time and tracks one outstanding read per ID. R-channel responses are routed back by RID. It sits between `fetch_stage`/the memory stage and the AXI bridge, and replaces the ad-hoc ID sharing done inside the fetch stage.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, read data width
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `inst_req` in 1: fetch read request, level, held until `inst_addr_ok`
- `inst_addr` in ADDR_W: fetch address
- `inst_addr_ok` out 1: fetch request accepted on AR
- `inst_rready` in 1: fetch can take data
- `inst_data_ok` out 1: fetch data beat valid
- `inst_rdata` out DATA_W: fetch data
- `data_req`, `data_addr`, `data_size[2:0]`, `data_addr_ok`, `data_rready`, `data_data_ok`, `data_rdata`: same as the fetch group, for loads; `data_size` is 0/1/2 for byte/half/word
- `arid` out 4: 0 = fetch, 1 = load
- `araddr` out ADDR_W
- `arlen` out 8: constant 0
- `arsize` out 3: 3'b010 for fetch, `data_size` for load
- `arburst` out 2: constant 2'b01
- `arvalid` out 1
- `arready` in 1
- `rid` in 4
- `rdata` in DATA_W
- `rresp` in 2: ignored
- `rlast` in 1
- `rvalid` in 1
- `rready` out 1

## Operation
- **State machine**
  - `IDLE`: grant-eligible requesters are those with `req` high and their outstanding bit clear.
    - If any requester is eligible: latch `arid`/`araddr`/`arsize` and move to `AR_WAIT`.
    - Otherwise stay in `IDLE`.
  - `AR_WAIT`: `arvalid` is 1 and `arid`/`araddr`/`arsize` are held stable.
    - On `arvalid & arready`: set `outstanding[arid]`, pulse the matching `*_addr_ok` for that cycle, return to `IDLE`.
- **Priority:** load beats fetch when both are eligible in the same `IDLE` cycle (default build).
- **Eligibility:** a requester whose outstanding bit is set is never eligible. The bit value used is the one at the start of the cycle, so a new issue cannot happen in the same cycle its previous response retires.
- **Response routing**
  - `rid == 0`: `rready = inst_rready` and `inst_data_ok = rvalid`.
  - `rid == 1`: `rready = data_rready` and `data_data_ok = rvalid`.
  - Any other `rid`: `rready = 1` (drained and dropped), neither `*_data_ok` asserts.
  - `*_rdata = rdata` (combinational).
- **Retire:** on `rvalid & rready & rlast & rid∈{0,1}`, clear `outstanding[rid]`.
- **Requester withdrawal:** if a requester drops `req` while in `AR_WAIT`, the beat is still completed (AXI forbids withdrawing `arvalid`).
- **Reset values:** state `IDLE`, `arvalid` 0, `arid` 0, `araddr` 0, `arsize` 0, outstanding bits 0, round-robin pointer 0. Every `*_addr_ok` and `*_data_ok` is 0 in the cycle after reset.
- **Reset mid-operation:** state returns to `IDLE` and outstanding bits clear. A pending R beat arriving after reset is routed combinationally but does not set or clear any state.

## Timing
- Grant evaluated in `IDLE` at cycle N → `arvalid` high from N+1.
- Minimum spacing between AR beats: 2 cycles (`IDLE` → `AR_WAIT` → `IDLE`).
- `*_addr_ok` is combinational in the handshake cycle: `arvalid & arready & (arid == id)`.
- R path is 0 cycles: `rready`, `*_data_ok` and `*_rdata` are combinational from `rid`/`rvalid`.
- At most 2 reads in flight (one per ID). An out-of-order return (load before fetch) is legal and routed correctly.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Fixed priority is replaced by round-robin.
  - A 1-bit pointer records the last granted ID; on a tie, the other ID wins.
  - The pointer updates only on grant.
- `ARB_ROUND_ROBIN_EN` undefined: fixed load-over-fetch priority and no pointer register.

## Test plan
- **Single fetch:** reset, `inst_req=1`, `inst_addr=0xBFC00000`, `arready=1`.
  - Required: `arvalid` high 1 cycle after the request, with `arid=0`, `arsize=2`, `inst_addr_ok` pulse.
  - Then `rvalid`, `rid=0`, `rdata=0x3C1DBFC0`, `rlast=1` → `inst_data_ok=1` with `inst_rdata=0x3C1DBFC0`.
- **Simultaneous requests:** fetch `0xBFC00004` and load `0x80001000` (`size=2`) in the same cycle.
  - Required: load AR first (`arid=1`), fetch AR two cycles later (`arid=0`).
  - With `ARB_ROUND_ROBIN_EN` and last grant = load, fetch goes first.
- **AR backpressure:** `arready=0` for 5 cycles.
  - Required: `arvalid`, `araddr`, `arid` stable throughout; a single `addr_ok` on the accepting cycle.
- **Out-of-order return:** both IDs outstanding, `rid=1` returns first with `data_rready=0` for 2 cycles.
  - Required: `rready=0` for those 2 cycles, then a `data_data_ok` beat; `inst_data_ok` stays 0 until the `rid=0` beat.
- **Outstanding block:** a second fetch request while fetch is outstanding.
  - Required: no AR until the `rid=0` `rlast` beat retires; AR issues no earlier than the following cycle.
- **Mid-operation reset:** `rst` asserted in `AR_WAIT`.
  - Required: `arvalid=0` the next cycle, outstanding bits 0, a new request is granted normally.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter (fetch = ID 0, load = ID 1), one AR beat at a time, one read in flight per ID.
// Define ARB_ROUND_ROBIN_EN to replace fixed load-over-fetch priority with round-robin.
module axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  input  logic              inst_rready,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [2:0]        data_size,
  output logic              data_addr_ok,
  input  logic              data_rready,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic {IDLE, AR_WAIT} state_t;

  state_t     state;
  logic [1:0] outstanding;
  logic       elig_inst, elig_data, grant_data;
  logic       ar_fire, r_fire;
  logic       unused_rresp;

  assign unused_rresp = ^rresp;
  assign elig_inst    = inst_req & ~outstanding[0];
  assign elig_data    = data_req & ~outstanding[1];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
  // On a tie the ID that did not win last time goes first.
  assign grant_data = elig_data & (~elig_inst | ~last_grant);
`else
  assign grant_data = elig_data;
`endif

  assign ar_fire = arvalid & arready;
  assign r_fire  = rvalid & rready & rlast & (rid[3:1] == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      arvalid     <= 1'b0;
      arid        <= 4'd0;
      araddr      <= '0;
      arsize      <= 3'd0;
      outstanding <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      // Retire first so a handshake in the same cycle still sets its own bit.
      if (r_fire)
        outstanding[rid[0]] <= 1'b0;
      case (state)
        IDLE: begin
          if (elig_inst | elig_data) begin
            state   <= AR_WAIT;
            arvalid <= 1'b1;
            arid    <= grant_data ? 4'd1 : 4'd0;
            araddr  <= grant_data ? data_addr : inst_addr;
            arsize  <= grant_data ? data_size : 3'b010;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= grant_data;
`endif
          end
        end
        AR_WAIT: begin
          if (arready) begin
            state                 <= IDLE;
            arvalid               <= 1'b0;
            outstanding[arid[0]]  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arlen        = 8'd0;
  assign arburst      = 2'b01;
  assign inst_addr_ok = ar_fire & (arid == 4'd0);
  assign data_addr_ok = ar_fire & (arid == 4'd1);

  always_comb begin
    rready       = 1'b1;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    if (rid == 4'd0) begin
      rready       = inst_rready;
      inst_data_ok = rvalid;
    end else if (rid == 4'd1) begin
      rready       = data_rready;
      data_data_ok = rvalid;
    end
  end

  assign inst_rdata = rdata;
  assign data_rdata = rdata;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grant order, backpressure, response routing, retire timing, reset.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_rready, data_req, data_rready;
  logic [31:0] inst_addr, data_addr;
  logic [2:0]  data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rready(inst_rready), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_rready(data_rready), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = 0; inst_rready = 0;
    data_req = 0; data_addr = 0; data_size = 0; data_rready = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_arid", arid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arsize", arsize, 0);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("arlen", arlen, 0);
    chk("arburst", arburst, 1);

    // Single fetch
    inst_req = 1; inst_addr = 32'hBFC0_0000; arready = 1;
    step();
    chk("f1_arvalid", arvalid, 1);
    chk("f1_arid", arid, 0);
    chk("f1_arsize", arsize, 3'd2);
    chk("f1_araddr", araddr, 32'hBFC0_0000);
    chk("f1_addr_ok", inst_addr_ok, 1);
    chk("f1_data_addr_ok", data_addr_ok, 0);
    inst_req = 0;
    step();
    chk("f1_arvalid_drop", arvalid, 0);
    rvalid = 1; rid = 0; rdata = 32'h3C1D_BFC0; rlast = 1; inst_rready = 1;
    #1;
    chk("f1_data_ok", inst_data_ok, 1);
    chk("f1_rdata", inst_rdata, 32'h3C1D_BFC0);
    chk("f1_rready", rready, 1);
    chk("f1_no_load_ok", data_data_ok, 0);
    step();
    rvalid = 0; rlast = 0;

    // Simultaneous: load first, fetch two cycles later
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_addr = 32'h8000_1000; data_size = 3'd2;
    step();
    chk("sim_arid_load", arid, 1);
    chk("sim_araddr_load", araddr, 32'h8000_1000);
    chk("sim_load_addr_ok", data_addr_ok, 1);
    chk("sim_no_inst_ok", inst_addr_ok, 0);
    data_req = 0;
    step();
    chk("sim_gap", arvalid, 0);
    step();
    chk("sim_arvalid_fetch", arvalid, 1);
    chk("sim_arid_fetch", arid, 0);
    chk("sim_araddr_fetch", araddr, 32'hBFC0_0004);
    chk("sim_fetch_addr_ok", inst_addr_ok, 1);
    inst_req = 0;
    step();

    // Out-of-order: load returns first, stalled 2 cycles
    rvalid = 1; rid = 1; rdata = 32'hDEAD_BEEF; rlast = 1; data_rready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("ooo_rready_stall", rready, 0);
      chk("ooo_inst_quiet", inst_data_ok, 0);
      step();
    end
    data_rready = 1;
    #1;
    chk("ooo_rready", rready, 1);
    chk("ooo_data_ok", data_data_ok, 1);
    chk("ooo_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("ooo_inst_quiet2", inst_data_ok, 0);
    step();
    rvalid = 0; rlast = 0;

    // Unknown RID drained
    rvalid = 1; rid = 4'd3; inst_rready = 0; data_rready = 0;
    #1;
    chk("drain_rready", rready, 1);
    chk("drain_no_ok", {inst_data_ok, data_data_ok}, 0);
    rvalid = 0; rid = 0;

    // Outstanding block: fetch still in flight
    inst_req = 1; inst_addr = 32'hBFC0_0008; arready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blk_no_ar", arvalid, 0);
    end
    rvalid = 1; rid = 0; rdata = 32'h1234_5678; rlast = 1; inst_rready = 1;
    #1;
    chk("blk_ret_ok", inst_data_ok, 1);
    step();
    rvalid = 0; rlast = 0;
    chk("blk_no_same_cycle", arvalid, 0);
    step();
    chk("blk_ar_after", arvalid, 1);
    chk("blk_araddr", araddr, 32'hBFC0_0008);

    // Backpressure for 5 cycles, requester withdraws meanwhile
    inst_req = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_arvalid", arvalid, 1);
      chk("bp_araddr", araddr, 32'hBFC0_0008);
      chk("bp_arid", arid, 0);
      chk("bp_no_ok", inst_addr_ok, 0);
      step();
    end
    arready = 1;
    #1;
    chk("bp_accept_ok", inst_addr_ok, 1);
    step();
    chk("bp_done", arvalid, 0);
    chk("bp_single_ok", inst_addr_ok, 0);

    // Mid-operation reset while a load sits in AR_WAIT (fetch outstanding)
    arready = 0; data_req = 1; data_addr = 32'h8000_2000; data_size = 3'd0;
    step();
    chk("mr_arid", arid, 1);
    chk("mr_arsize", arsize, 0);
    rst = 1;
    step();
    rst = 0; data_req = 0;
    chk("mr_arvalid", arvalid, 0);
    chk("mr_araddr", araddr, 0);
    inst_req = 1; inst_addr = 32'hBFC0_000C; arready = 1;
    step();
    chk("mr_regrant", arvalid, 1);
    chk("mr_regrant_id", arid, 0);
    chk("mr_regrant_addr", araddr, 32'hBFC0_000C);
    inst_req = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
